mouse_init_ctrl: RTL



---
 rtl/mouse_init_ctrl.sv | 244 ++++++++++++++++++++++++
 1 files changed

// File: rtl/mouse_init_ctrl.sv
// mouse_init_ctrl
//
// Brings a PS/2 mouse from power-on to stream mode: sends reset (0xFF),
// checks the self-test result (0xAA) and device ID (0x00), optionally sets
// the sample rate (0xF3 + rate byte), then enables reporting (0xF4).
// Errors and response timeouts restart the whole sequence up to MAX_RETRIES
// times before parking in FAIL. o_stream_en is raised only once the mouse
// has acknowledged 0xF4.
//
// Optional feature: define MOUSE_INIT_SAMPLE_RATE_EN to add the sample-rate
// states and the SAMPLE_RATE parameter. Without it, ID goes straight to EN_TX.
//
// Ports:
//   clk, rst          system clock, asynchronous active-high reset
//   i_start           re-init request, honoured only in STREAM or FAIL
//   o_tx_valid/o_tx_data/i_tx_ready   command byte handshake to transmitter
//   i_rx_valid/i_rx_data              one-cycle received byte strobe
//   o_stream_en       high only in STREAM
//   o_busy            high outside IDLE, STREAM and FAIL
//   o_error           high only in FAIL
//   o_retry_cnt       failed attempts in the current init run
//
// All outputs are registered; nothing combinational reaches them from inputs.

module mouse_init_ctrl #(
    parameter int TIMEOUT_CYCLES = 25_000_000,
    parameter int MAX_RETRIES    = 3
`ifdef MOUSE_INIT_SAMPLE_RATE_EN
    ,
    parameter logic [7:0] SAMPLE_RATE = 8'd100
`endif
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       i_start,
    output logic       o_tx_valid,
    output logic [7:0] o_tx_data,
    input  logic       i_tx_ready,
    input  logic       i_rx_valid,
    input  logic [7:0] i_rx_data,
    output logic       o_stream_en,
    output logic       o_busy,
    output logic       o_error,
    output logic [1:0] o_retry_cnt
);

    // Counter only needs to reach TIMEOUT_CYCLES-1.
    localparam int              CW        = $clog2(TIMEOUT_CYCLES);
    localparam logic [CW-1:0]   TO_LAST   = CW'(TIMEOUT_CYCLES - 1);
    localparam logic [1:0]      RETRY_LIM = 2'(MAX_RETRIES);

    localparam logic [7:0] B_ACK    = 8'hFA;
    localparam logic [7:0] B_RESEND = 8'hFE;
    localparam logic [7:0] B_BAT_OK = 8'hAA;
    localparam logic [7:0] B_ID     = 8'h00;

    typedef enum logic [3:0] {
        S_IDLE,
        S_RST_TX,
        S_RST_ACK,
        S_BAT,
        S_ID,
`ifdef MOUSE_INIT_SAMPLE_RATE_EN
        S_RATE_TX,
        S_RATE_ACK,
        S_RVAL_TX,
        S_RVAL_ACK,
`endif
        S_EN_TX,
        S_EN_ACK,
        S_STREAM,
        S_FAIL
    } state_t;

    state_t        st, st_n;
    logic [1:0]    rc_n;
    logic          resent, rs_n;   // a 0xFE was already honoured for this byte
    logic [CW-1:0] cnt, cnt_n;
    logic          fail;
    logic          tx_fire;

    function automatic logic is_tx(input state_t s);
        case (s)
            S_RST_TX, S_EN_TX: return 1'b1;
`ifdef MOUSE_INIT_SAMPLE_RATE_EN
            S_RATE_TX, S_RVAL_TX: return 1'b1;
`endif
            default: return 1'b0;
        endcase
    endfunction

    function automatic logic is_ack(input state_t s);
        case (s)
            S_RST_ACK, S_EN_ACK: return 1'b1;
`ifdef MOUSE_INIT_SAMPLE_RATE_EN
            S_RATE_ACK, S_RVAL_ACK: return 1'b1;
`endif
            default: return 1'b0;
        endcase
    endfunction

    function automatic logic [7:0] tx_byte(input state_t s);
        case (s)
            S_RST_TX: return 8'hFF;
            S_EN_TX:  return 8'hF4;
`ifdef MOUSE_INIT_SAMPLE_RATE_EN
            S_RATE_TX: return 8'hF3;
            S_RVAL_TX: return SAMPLE_RATE;
`endif
            default:  return 8'h00;
        endcase
    endfunction

    // TX state -> the ACK state that waits on it.
    function automatic state_t tx_to_ack(input state_t s);
        case (s)
            S_RST_TX: return S_RST_ACK;
`ifdef MOUSE_INIT_SAMPLE_RATE_EN
            S_RATE_TX: return S_RATE_ACK;
            S_RVAL_TX: return S_RVAL_ACK;
`endif
            default:  return S_EN_ACK;
        endcase
    endfunction

    // ACK state -> the TX state to repeat on 0xFE.
    function automatic state_t ack_to_tx(input state_t s);
        case (s)
            S_RST_ACK: return S_RST_TX;
`ifdef MOUSE_INIT_SAMPLE_RATE_EN
            S_RATE_ACK: return S_RATE_TX;
            S_RVAL_ACK: return S_RVAL_TX;
`endif
            default:   return S_EN_TX;
        endcase
    endfunction

    // ACK state -> successor on 0xFA.
    function automatic state_t ack_next(input state_t s);
        case (s)
            S_RST_ACK: return S_BAT;
`ifdef MOUSE_INIT_SAMPLE_RATE_EN
            S_RATE_ACK: return S_RVAL_TX;
            S_RVAL_ACK: return S_EN_TX;
`endif
            default:   return S_STREAM;
        endcase
    endfunction

    assign tx_fire = o_tx_valid & i_tx_ready;

    always_comb begin
        st_n = st;
        rc_n = o_retry_cnt;
        rs_n = resent;
        fail = 1'b0;
        if (st == S_IDLE) begin
            st_n = S_RST_TX;
        end else if (is_tx(st)) begin
            if (tx_fire) st_n = tx_to_ack(st);
        end else if (is_ack(st)) begin
            // rx byte takes priority over a timeout on the same cycle
            if (i_rx_valid) begin
                if (i_rx_data == B_ACK) begin
                    st_n = ack_next(st);
                    rs_n = 1'b0;
                end else if (i_rx_data == B_RESEND && !resent) begin
                    st_n = ack_to_tx(st);
                    rs_n = 1'b1;
                end else begin
                    fail = 1'b1;
                end
            end else if (cnt == TO_LAST) begin
                fail = 1'b1;
            end
        end else if (st == S_BAT) begin
            if (i_rx_valid) begin
                if (i_rx_data == B_BAT_OK) st_n = S_ID;
                else                       fail = 1'b1;
            end else if (cnt == TO_LAST) begin
                fail = 1'b1;
            end
        end else if (st == S_ID) begin
            if (i_rx_valid) begin
`ifdef MOUSE_INIT_SAMPLE_RATE_EN
                if (i_rx_data == B_ID) st_n = S_RATE_TX;
`else
                if (i_rx_data == B_ID) st_n = S_EN_TX;
`endif
                else                   fail = 1'b1;
            end else if (cnt == TO_LAST) begin
                fail = 1'b1;
            end
        end else begin
            // STREAM / FAIL: terminal until a re-init request
            if (i_start) begin
                st_n = S_IDLE;
                rc_n = 2'd0;
                rs_n = 1'b0;
            end
        end

        if (fail) begin
            rs_n = 1'b0;
            if (o_retry_cnt < RETRY_LIM) begin
                rc_n = o_retry_cnt + 2'd1;
                st_n = S_RST_TX;
            end else begin
                st_n = S_FAIL;
            end
        end

        // Restart on any state change or received byte; idle outside waits.
        if (st_n == st && !i_rx_valid && (is_ack(st) || st == S_BAT || st == S_ID))
            cnt_n = cnt + 1'b1;
        else
            cnt_n = '0;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            st          <= S_IDLE;
            o_retry_cnt <= 2'd0;
            resent      <= 1'b0;
            cnt         <= '0;
            o_tx_valid  <= 1'b0;
            o_tx_data   <= 8'h00;
            o_stream_en <= 1'b0;
            o_busy      <= 1'b0;
            o_error     <= 1'b0;
        end else begin
            st          <= st_n;
            o_retry_cnt <= rc_n;
            resent      <= rs_n;
            cnt         <= cnt_n;
            o_tx_valid  <= is_tx(st_n);
            o_tx_data   <= tx_byte(st_n);
            o_stream_en <= (st_n == S_STREAM);
            o_error     <= (st_n == S_FAIL);
            o_busy      <= !(st_n == S_IDLE || st_n == S_STREAM || st_n == S_FAIL);
        end
    end

endmodule
